// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the load/ALU sources and the register-file write arbiter.
// master = sources and hazard logic, slave = the arbiter.
interface rf_wb_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          alu_valid;
   logic          alu_ready;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic [AW-1:0] q_addr;
   logic          q_pending;

   modport master (
      output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, q_addr,
      input  alu_ready, rf_we, rf_wa, rf_wd, q_pending
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, q_addr,
      output alu_ready, rf_we, rf_wa, rf_wd, q_pending
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: loads win, ALU writebacks queue in order.
// Optional RF_WB_BYPASS_EN sends idle-cycle ALU writes straight to the output stage.
module rf_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   rf_wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   entry_t [DEPTH-1:0] q;
   entry_t             head;
   logic [PW-1:0]      rd_ptr, wr_ptr;
   logic [PW:0]        count;
   logic               ld_sel, alu_acc, byp, enq, deq, hit;
   logic               we_d;
   logic [AW-1:0]      wa_d;
   logic [DW-1:0]      wd_d;

   assign head          = q[rd_ptr];
   assign bus.alu_ready = (count != (PW+1)'(DEPTH));
   assign ld_sel        = bus.ld_valid && (bus.ld_addr != '0);
   // x0 requests are handshaken but dropped on the floor
   assign alu_acc       = bus.alu_valid && bus.alu_ready && (bus.alu_addr != '0);
`ifdef RF_WB_BYPASS_EN
   assign byp           = alu_acc && (count == '0) && !ld_sel;
`else
   assign byp           = 1'b0;
`endif
   assign enq           = alu_acc && !byp;
   assign deq           = !ld_sel && (count != '0);

   always_comb begin
      we_d = 1'b0;
      wa_d = bus.rf_wa;
      wd_d = bus.rf_wd;
      if (ld_sel) begin
         we_d = 1'b1;
         wa_d = bus.ld_addr;
         wd_d = bus.ld_data;
      end else if (deq) begin
         // killed entries still consume a slot, just without a write
         if (head.vld) begin
            we_d = 1'b1;
            wa_d = head.addr;
            wd_d = head.data;
         end
      end else if (byp) begin
         we_d = 1'b1;
         wa_d = bus.alu_addr;
         wd_d = bus.alu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rf_we <= 1'b0;
         bus.rf_wa <= '0;
         bus.rf_wd <= '0;
      end else begin
         bus.rf_we <= we_d;
         bus.rf_wa <= wa_d;
         bus.rf_wd <= wd_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q      <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         // a selected load supersedes older queued writes to the same register
         for (int i = 0; i < DEPTH; i++)
            if (ld_sel && (q[i].addr == bus.ld_addr)) q[i].vld <= 1'b0;
         if (deq) begin
            q[rd_ptr].vld <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         // same-cycle ALU request is newer than the load, so it lands after the kill
         if (enq) begin
            q[wr_ptr] <= {1'b1, bus.alu_addr, bus.alu_data};
            wr_ptr    <= wr_ptr + 1'b1;
         end
         count <= count + (PW+1)'(enq) - (PW+1)'(deq);
      end
   end

   always_comb begin
      hit = bus.rf_we && (bus.rf_wa == bus.q_addr);
      for (int i = 0; i < DEPTH; i++)
         if (q[i].vld && (q[i].addr == bus.q_addr)) hit = 1'b1;
   end

   assign bus.q_pending = hit && (bus.q_addr != '0);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus queues expected writes and probes,
// a monitor process samples the DUT and compares.
module tb_rf_wb_arbiter;
   localparam int K_WE = 0, K_WA = 1, K_WD = 2, K_RDY = 3, K_PND = 4;

   typedef struct {
      int          cyc;
      logic [4:0]  a;
      logic [31:0] d;
      string       name;
   } exp_t;

   typedef struct {
      int          cyc;
      bit          in_rst;
      int          kind;
      logic [31:0] exp;
      string       name;
   } probe_t;

   logic clk = 1'b0;
   logic rst_n;
   logic done = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t   sb[$];
   probe_t pq[$];

   rf_wb_arbiter_if #(.AW(5), .DW(32)) bus ();
   rf_wb_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
      bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d);
      bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = d;
   endtask

   task automatic ld(input logic [4:0] a, input logic [31:0] d);
      bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_data = d;
   endtask

   task automatic exp_wr(input int c, input logic [4:0] a, input logic [31:0] d, input string n);
      exp_t e;
      e.cyc = c; e.a = a; e.d = d; e.name = n;
      sb.push_back(e);
   endtask

   task automatic probe(input int k, input logic [31:0] e, input string n);
      probe_t p;
      p.cyc = cyc; p.in_rst = !rst_n; p.kind = k; p.exp = e; p.name = n;
      pq.push_back(p);
   endtask

   function automatic logic [31:0] sample(input int k);
      case (k)
         K_WE:    return {31'b0, bus.rf_we};
         K_WA:    return {27'b0, bus.rf_wa};
         K_WD:    return bus.rf_wd;
         K_RDY:   return {31'b0, bus.alu_ready};
         default: return {31'b0, bus.q_pending};
      endcase
   endfunction

   // monitor: all comparisons live here
   initial begin
      probe_t p;
      exp_t   e;
      logic [31:0] act;
      forever begin
         @(negedge clk or negedge rst_n or posedge done);
         #1;
         if (done) break;
         while (pq.size() > 0 &&
                (pq[0].cyc < cyc || (pq[0].cyc == cyc && pq[0].in_rst == !rst_n))) begin
            p = pq.pop_front();
            checks++;
            if (p.cyc != cyc) begin
               errors++;
               $display("FAIL %s: probe for cycle %0d not sampled (now %0d)", p.name, p.cyc, cyc);
            end else begin
               act = sample(p.kind);
               if (act !== p.exp) begin
                  errors++;
                  $display("FAIL %s: got %h expected %h (cycle %0d)", p.name, act, p.exp, cyc);
               end
            end
         end
         if (rst_n && clk == 1'b0 && bus.rf_we) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got x%0d=%h at cycle %0d, expected none",
                        bus.rf_wa, bus.rf_wd, cyc);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || e.a != bus.rf_wa || e.d != bus.rf_wd) begin
                  errors++;
                  $display("FAIL %s: got x%0d=%h at cycle %0d, expected x%0d=%h at cycle %0d",
                           e.name, bus.rf_wa, bus.rf_wd, cyc, e.a, e.d, e.cyc);
               end
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_writes: %0d outstanding, first %s expected at cycle %0d",
                  sb.size(), sb[0].name, sb[0].cyc);
      end
      checks++;
      if (pq.size() != 0) begin
         errors++;
         $display("FAIL unsampled_probes: %0d outstanding, expected 0", pq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected done by 100000");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      idle();
      bus.q_addr = 5'd5;

      // reset state
      step();
      probe(K_WE, 0, "rst_we"); probe(K_WA, 0, "rst_wa"); probe(K_WD, 0, "rst_wd");
      probe(K_RDY, 1, "rst_ready"); probe(K_PND, 0, "rst_pending");
      step();
      rst_n = 1'b1;
      step();

      // priority: ALU x5 then two loads to x6
      n = cyc;
      alu(5'd5, 32'h11);
`ifdef RF_WB_BYPASS_EN
      exp_wr(n + 1, 5'd5, 32'h11, "prio_alu_x5");
`endif
      step(); idle();
      ld(5'd6, 32'h600); exp_wr(n + 2, 5'd6, 32'h600, "prio_ld0");
`ifndef RF_WB_BYPASS_EN
      bus.q_addr = 5'd5; probe(K_PND, 1, "prio_pending_x5");
`endif
      step(); ld(5'd6, 32'h601); exp_wr(n + 3, 5'd6, 32'h601, "prio_ld1");
      step(); idle();
`ifndef RF_WB_BYPASS_EN
      exp_wr(n + 4, 5'd5, 32'h11, "prio_alu_x5");
`endif
      repeat (3) step();

      // backpressure and pointer wrap under a load stream
      n = cyc;
      ld(5'd9, 32'h900); alu(5'd10, 32'hA1); probe(K_RDY, 1, "bp_rdy0");
      exp_wr(n + 1, 5'd9, 32'h900, "bp_ld0");
      step(); ld(5'd9, 32'h901); alu(5'd11, 32'hA2); probe(K_RDY, 1, "bp_rdy1");
      exp_wr(n + 2, 5'd9, 32'h901, "bp_ld1");
      step(); ld(5'd9, 32'h902); alu(5'd12, 32'hA3); probe(K_RDY, 0, "bp_full0");
      exp_wr(n + 3, 5'd9, 32'h902, "bp_ld2");
      step(); ld(5'd9, 32'h903); probe(K_RDY, 0, "bp_full1");
      bus.q_addr = 5'd10; probe(K_PND, 1, "bp_pending_x10");
      exp_wr(n + 4, 5'd9, 32'h903, "bp_ld3");
      step(); bus.ld_valid = 1'b0; probe(K_RDY, 0, "bp_full_on_deq");
      exp_wr(n + 5, 5'd10, 32'hA1, "bp_a1");
      step(); probe(K_RDY, 1, "bp_rdy_after_deq");
      exp_wr(n + 6, 5'd11, 32'hA2, "bp_a2");
      step(); idle();
      exp_wr(n + 7, 5'd12, 32'hA3, "bp_a3_wrapped");
      repeat (3) step();
      probe(K_RDY, 1, "bp_drained_ready");

      // kill: queued x7 superseded by a later load to x7
      step();
      n = cyc;
      ld(5'd8, 32'h88); alu(5'd7, 32'hAA);
      exp_wr(n + 1, 5'd8, 32'h88, "kill_ld_x8");
      step(); idle(); ld(5'd7, 32'hBB);
      exp_wr(n + 2, 5'd7, 32'hBB, "kill_ld_x7");
      bus.q_addr = 5'd7; probe(K_PND, 1, "kill_pend_queued");
      step(); idle(); probe(K_PND, 1, "kill_pend_outstage");
      step(); probe(K_PND, 0, "kill_pend_cleared");
      repeat (3) step();

      // x0 writes never happen and never occupy the queue
      n = cyc;
      bus.q_addr = 5'd0;
      for (int i = 0; i < 3; i++) begin
         alu(5'd0, 32'hFFFF_FFFF); ld(5'd1, 32'h100 + i);
         exp_wr(n + 1 + i, 5'd1, 32'h100 + i, "x0_ld_x1");
         probe(K_RDY, 1, "x0_ready");
         probe(K_PND, 0, "x0_pending");
         step();
      end
      alu(5'd0, 32'hFFFF_FFFF); ld(5'd0, 32'hFFFF_FFFF);
      probe(K_RDY, 1, "x0_ready_last"); probe(K_PND, 0, "x0_pending_last");
      step(); idle();
      repeat (3) step();

      // idle ALU request to x3: latency depends on the bypass build
      n = cyc;
      alu(5'd3, 32'h33);
`ifdef RF_WB_BYPASS_EN
      exp_wr(n + 1, 5'd3, 32'h33, "byp_x3");
`else
      exp_wr(n + 2, 5'd3, 32'h33, "nobyp_x3");
`endif
      step(); idle();
      bus.q_addr = 5'd3; probe(K_PND, 1, "x3_pending");
      repeat (3) step();

      // reset mid-drain with two ALU entries queued
      n = cyc;
      ld(5'd13, 32'hD0); alu(5'd12, 32'hC12);
      exp_wr(n + 1, 5'd13, 32'hD0, "rst_ld0");
      step(); ld(5'd13, 32'hD1); alu(5'd14, 32'hC14);
      exp_wr(n + 2, 5'd13, 32'hD1, "rst_ld1");
      step(); idle();
      bus.q_addr = 5'd12; probe(K_PND, 1, "rst_pend_before");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      probe(K_WE, 0, "rst_async_we"); probe(K_RDY, 1, "rst_async_ready");
      probe(K_PND, 0, "rst_async_pending");
      step();
      rst_n = 1'b1;
      bus.q_addr = 5'd14;
      probe(K_RDY, 1, "post_rst_ready"); probe(K_PND, 0, "post_rst_pending");
      repeat (5) step();
      done = 1'b1;
   end
endmodule
